// File: rtl/ezrisc_pkg.sv
// Shared ezRISC definitions: opcodes, sequencer step encoding, the strobe bundle
// and the register-number to one-hot select mapping.
package ezrisc_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_OR   = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    // Datapath strobes plus the register-field selects handed to reg_select_encode.
    typedef struct packed {
        logic       pc_in;
        logic       pc_out;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       z_low_out;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       c_out;
        logic       inc_pc;
        logic       read;
        logic       write;
        logic [4:0] alu_op;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       base_mode;
    } strobe_t;

    function automatic logic [15:0] reg_onehot(input logic [3:0] n);
        logic [15:0] v;
        v = 16'h8000;
        return v >> n;
    endfunction

    function automatic logic is_rtype(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_OR);
    endfunction

    function automatic logic is_imm(input logic [4:0] op);
        return (op >= OP_ADDI) && (op <= OP_ORI);
    endfunction

    function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
        logic [4:0] r;
        case (op)
            OP_ANDI: r = OP_AND;
            OP_ORI:  r = OP_OR;
            default: r = OP_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer (master) and the ezRISC datapath/memory (slave).
interface control_sequencer_if;
    // read/write stay asserted and the sequencer holds its wait step until mem_ready=1
    // is sampled on a rising edge; mem_ready is ignored outside wait steps.
    logic [31:0] ir;
    logic        mem_ready;
    logic [15:0] gpr_in;
    logic [15:0] gpr_out;
    logic        ba_out;
    logic        pc_in;
    logic        pc_out;
    logic        ir_in;
    logic        y_in;
    logic        z_in;
    logic        z_low_out;
    logic        mar_in;
    logic        mdr_in;
    logic        mdr_out;
    logic        c_out;
    logic        inc_pc;
    logic        read;
    logic        write;
    logic [4:0]  alu_op;
    logic        halted;
    logic        mem_fault;

    modport master (
        input  ir, mem_ready,
        output gpr_in, gpr_out, ba_out, pc_in, pc_out, ir_in, y_in, z_in, z_low_out,
               mar_in, mdr_in, mdr_out, c_out, inc_pc, read, write, alu_op, halted, mem_fault
    );

    modport slave (
        output ir, mem_ready,
        input  gpr_in, gpr_out, ba_out, pc_in, pc_out, ir_in, y_in, z_in, z_low_out,
               mar_in, mdr_in, mdr_out, c_out, inc_pc, read, write, alu_op, halted, mem_fault
    );
endinterface

// File: rtl/control_sequencer_reg_select_encode.sv
// Turns the ra/rb/rc field selects into one-hot register load/drive lines (R_n on bit 15-n)
// and the zero-base strobe used when R0 is the base of a memory address.
module reg_select_encode
    import ezrisc_pkg::*;
(
    input  logic [31:0] i_ir,
    input  logic        i_gra,
    input  logic        i_grb,
    input  logic        i_grc,
    input  logic        i_r_in,
    input  logic        i_r_out,
    input  logic        i_base_mode,
    output logic [15:0] o_gpr_in,
    output logic [15:0] o_gpr_out,
    output logic        o_ba_out
);
    logic [3:0]  w_idx;
    logic        w_any;
    logic        w_base;
    logic [15:0] w_sel;
    logic        w_unused_ir;

    assign w_unused_ir = ^{i_ir[31:27], i_ir[14:0]};

    always_comb begin
        w_idx = 4'd0;
        if (i_gra)      w_idx = i_ir[26:23];
        else if (i_grb) w_idx = i_ir[22:19];
        else if (i_grc) w_idx = i_ir[18:15];
    end

    assign w_any = i_gra | i_grb | i_grc;
    assign w_sel = reg_onehot(w_idx);

    // R0 as a base register means address zero, so the register bus stays quiet.
    assign w_base    = i_base_mode & i_grb & i_r_out & (i_ir[22:19] == 4'd0);
    assign o_gpr_in  = (i_r_in & w_any) ? w_sel : 16'h0000;
    assign o_gpr_out = (i_r_out & w_any & ~w_base) ? w_sel : 16'h0000;
    assign o_ba_out  = w_base;
endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer: Moore-decodes datapath strobes from the
// current step and the instruction register, with a bounded wait on memory.
module control_sequencer
    import ezrisc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master ctl,
    output state_t              o_state
);
    state_t          r_state;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_fault;
    logic            r_idle;

    state_t          w_next;
    strobe_t         w_stb;
    logic [4:0]      w_op;
    logic            w_is_r, w_is_imm, w_is_ld, w_is_ldi, w_is_st, w_is_mem, w_known;
    logic            w_wait, w_timeout;

    assign w_op     = ctl.ir[31:27];
    assign w_is_r   = is_rtype(w_op);
    assign w_is_imm = is_imm(w_op);
    assign w_is_ld  = (w_op == OP_LD);
    assign w_is_ldi = (w_op == OP_LDI);
    assign w_is_st  = (w_op == OP_ST);
    assign w_is_mem = w_is_ld | w_is_ldi | w_is_st;
    assign w_known  = w_is_r | w_is_imm | w_is_mem;

    assign w_wait    = (r_state == S_T1) || (r_state == S_T6 && w_is_ld) ||
                       (r_state == S_T7 && w_is_st);
    assign w_timeout = w_wait && !ctl.mem_ready && (r_to_cnt == TO_W'(MEM_TIMEOUT - 1));

    // r_idle covers the cycles right after reset is sampled: everything quiet, T0 next.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_T0;
            r_to_cnt <= '0;
            r_fault  <= 1'b0;
            r_idle   <= 1'b1;
        end else begin
            r_idle <= 1'b0;
            if (!r_idle) begin
                r_state <= w_next;
                if (w_next != r_state)
                    r_to_cnt <= '0;
                else if (w_wait && !ctl.mem_ready)
                    r_to_cnt <= r_to_cnt + 1'b1;
                if (w_timeout)
                    r_fault <= 1'b1;
            end
        end
    end

    always_comb begin
        w_stb  = '0;
        w_next = r_state;
        if (!r_idle) begin
            case (r_state)
                S_T0: begin
                    w_stb.pc_out = 1'b1; w_stb.mar_in = 1'b1; w_stb.inc_pc = 1'b1; w_stb.z_in = 1'b1;
                    w_next = S_T1;
                end
                S_T1: begin
                    w_stb.z_low_out = 1'b1; w_stb.pc_in = 1'b1; w_stb.read = 1'b1; w_stb.mdr_in = 1'b1;
                    if (ctl.mem_ready) w_next = S_T2;
                    else if (w_timeout) w_next = S_HALT;
                end
                S_T2: begin
                    w_stb.mdr_out = 1'b1; w_stb.ir_in = 1'b1;
                    if (w_op == OP_NOP) w_next = S_T0;
                    else if (w_known)   w_next = S_T3;
                    else                w_next = S_HALT;
                end
                S_T3: begin
                    if (w_known) begin
                        w_stb.grb = 1'b1; w_stb.r_out = 1'b1; w_stb.base_mode = w_is_mem;
                        w_stb.y_in = 1'b1;
                        w_next = S_T4;
                    end else w_next = S_HALT;
                end
                S_T4: begin
                    if (w_known) begin
                        w_stb.z_in = 1'b1;
                        if (w_is_r) begin
                            w_stb.grc = 1'b1; w_stb.r_out = 1'b1; w_stb.alu_op = w_op;
                        end else begin
                            w_stb.c_out  = 1'b1;
                            w_stb.alu_op = w_is_imm ? imm_alu_op(w_op) : OP_ADD;
                        end
                        w_next = S_T5;
                    end else w_next = S_HALT;
                end
                S_T5: begin
                    if (w_known) begin
                        w_stb.z_low_out = 1'b1;
                        if (w_is_ld || w_is_st) begin
                            w_stb.mar_in = 1'b1;
                            w_next = S_T6;
                        end else begin
                            w_stb.gra = 1'b1; w_stb.r_in = 1'b1;
                            w_next = S_T0;
                        end
                    end else w_next = S_HALT;
                end
                S_T6: begin
                    if (w_is_ld) begin
                        w_stb.read = 1'b1; w_stb.mdr_in = 1'b1;
                        if (ctl.mem_ready) w_next = S_T7;
                        else if (w_timeout) w_next = S_HALT;
                    end else if (w_is_st) begin
                        w_stb.gra = 1'b1; w_stb.r_out = 1'b1; w_stb.mdr_in = 1'b1;
                        w_next = S_T7;
                    end else w_next = S_HALT;
                end
                S_T7: begin
                    if (w_is_ld) begin
                        w_stb.mdr_out = 1'b1; w_stb.gra = 1'b1; w_stb.r_in = 1'b1;
                        w_next = S_T0;
                    end else if (w_is_st) begin
                        w_stb.write = 1'b1;
                        if (ctl.mem_ready) w_next = S_T0;
                        else if (w_timeout) w_next = S_HALT;
                    end else w_next = S_HALT;
                end
                default: w_next = S_HALT;
            endcase
        end
    end

    reg_select_encode u_sel (
        .i_ir        (ctl.ir),
        .i_gra       (w_stb.gra),
        .i_grb       (w_stb.grb),
        .i_grc       (w_stb.grc),
        .i_r_in      (w_stb.r_in),
        .i_r_out     (w_stb.r_out),
        .i_base_mode (w_stb.base_mode),
        .o_gpr_in    (ctl.gpr_in),
        .o_gpr_out   (ctl.gpr_out),
        .o_ba_out    (ctl.ba_out)
    );

    assign ctl.pc_in     = w_stb.pc_in;
    assign ctl.pc_out    = w_stb.pc_out;
    assign ctl.ir_in     = w_stb.ir_in;
    assign ctl.y_in      = w_stb.y_in;
    assign ctl.z_in      = w_stb.z_in;
    assign ctl.z_low_out = w_stb.z_low_out;
    assign ctl.mar_in    = w_stb.mar_in;
    assign ctl.mdr_in    = w_stb.mdr_in;
    assign ctl.mdr_out   = w_stb.mdr_out;
    assign ctl.c_out     = w_stb.c_out;
    assign ctl.inc_pc    = w_stb.inc_pc;
    assign ctl.read      = w_stb.read;
    assign ctl.write     = w_stb.write;
    assign ctl.alu_op    = w_stb.alu_op;
    assign ctl.halted    = !r_idle && (r_state == S_HALT);
    assign ctl.mem_fault = r_fault;
    assign o_state       = r_state;
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: an instruction-level model expands each instruction into its
// per-cycle strobe pattern, mem_ready and ir drive values; the DUT is compared every cycle.
module tb_control_sequencer;
    import ezrisc_pkg::*;

    localparam int W           = 53;
    localparam int MEM_TIMEOUT = 255;

    typedef struct packed {
        logic [15:0] gpr_in;
        logic [15:0] gpr_out;
        logic        ba_out, pc_in, pc_out, ir_in, y_in, z_in, z_low_out, mar_in;
        logic        mdr_in, mdr_out, c_out, inc_pc, read, write;
        logic [4:0]  alu_op;
        logic        halted, mem_fault;
    } obs_t;

    logic   clk;
    logic   reset;
    state_t dbg_state;

    logic [W-1:0] exp_q[$];
    logic         rdy_q[$];
    logic [31:0]  ir_q[$];
    int           n_checks;
    int           n_pass;

    control_sequencer_if ctl();

    control_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .ctl     (ctl),
        .o_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // reference model
    function automatic logic [15:0] rbit(input int n);
        return 16'(32'd1 << (15 - n));
    endfunction

    task automatic push(input obs_t o, input logic rdy, input logic [31:0] irv);
        exp_q.push_back(o);
        rdy_q.push_back(rdy);
        ir_q.push_back(irv);
    endtask

    task automatic push_free(input obs_t o, input logic [31:0] irv);
        push(o, 1'($urandom_range(0, 1)), irv);
    endtask

    task automatic push_frozen(input logic [31:0] irv, input logic fault);
        obs_t o;
        o = '0;
        o.halted = 1'b1;
        o.mem_fault = fault;
        repeat (3) push_free(o, irv);
    endtask

    task automatic push_wait(input obs_t o, input int lo, input logic [31:0] irv, output bit faulted);
        faulted = 0;
        if (lo >= MEM_TIMEOUT) begin
            repeat (MEM_TIMEOUT) push(o, 1'b0, irv);
            push_frozen(irv, 1'b1);
            faulted = 1;
        end else begin
            repeat (lo) push(o, 1'b0, irv);
            push(o, 1'b1, irv);
        end
    endtask

    task automatic model_instr(input logic [31:0] irv, input int f_lo, input int d_lo);
        obs_t o;
        bit   flt;
        int   op, ra, rb, rc;
        bit   r_alu, imm, ld, ldi, st;
        op = int'(irv[31:27]);
        ra = int'(irv[26:23]);
        rb = int'(irv[22:19]);
        rc = int'(irv[18:15]);
        r_alu = (op >= 3) && (op <= 10);
        imm   = (op >= 11) && (op <= 13);
        ld = (op == 0); ldi = (op == 1); st = (op == 2);

        o = '0; o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
        push_free(o, irv);
        o = '0; o.z_low_out = 1; o.pc_in = 1; o.read = 1; o.mdr_in = 1;
        push_wait(o, f_lo, irv, flt);
        if (flt) return;
        o = '0; o.mdr_out = 1; o.ir_in = 1;
        push_free(o, irv);
        if (op == 26) return;
        if (!(r_alu || imm || ld || ldi || st)) begin
            push_frozen(irv, 1'b0);
            return;
        end
        o = '0; o.y_in = 1;
        if ((ld || ldi || st) && rb == 0) o.ba_out = 1;
        else o.gpr_out = rbit(rb);
        push_free(o, irv);
        o = '0; o.z_in = 1;
        if (r_alu) begin
            o.gpr_out = rbit(rc);
            o.alu_op  = 5'(op);
        end else begin
            o.c_out  = 1;
            o.alu_op = (op == 12) ? 5'd9 : (op == 13) ? 5'd10 : 5'd3;
        end
        push_free(o, irv);
        o = '0; o.z_low_out = 1;
        if (ld || st) o.mar_in = 1;
        else o.gpr_in = rbit(ra);
        push_free(o, irv);
        if (ld) begin
            o = '0; o.read = 1; o.mdr_in = 1;
            push_wait(o, d_lo, irv, flt);
            if (flt) return;
            o = '0; o.mdr_out = 1; o.gpr_in = rbit(ra);
            push_free(o, irv);
        end else if (st) begin
            o = '0; o.gpr_out = rbit(ra); o.mdr_in = 1;
            push_free(o, irv);
            o = '0; o.write = 1;
            push_wait(o, d_lo, irv, flt);
        end
    endtask

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
        return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'($urandom_range(0, 32767))};
    endfunction

    // drivers
    function automatic logic [W-1:0] sample();
        obs_t o;
        o.gpr_in = ctl.gpr_in;   o.gpr_out = ctl.gpr_out; o.ba_out = ctl.ba_out;
        o.pc_in = ctl.pc_in;     o.pc_out = ctl.pc_out;   o.ir_in = ctl.ir_in;
        o.y_in = ctl.y_in;       o.z_in = ctl.z_in;       o.z_low_out = ctl.z_low_out;
        o.mar_in = ctl.mar_in;   o.mdr_in = ctl.mdr_in;   o.mdr_out = ctl.mdr_out;
        o.c_out = ctl.c_out;     o.inc_pc = ctl.inc_pc;   o.read = ctl.read;
        o.write = ctl.write;     o.alu_op = ctl.alu_op;   o.halted = ctl.halted;
        o.mem_fault = ctl.mem_fault;
        return o;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        ctl.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        rdy_q.delete();
        ir_q.delete();
    endtask

    task automatic step(output logic [W-1:0] got, output logic [W-1:0] exp);
        @(posedge clk); #1;
        ctl.ir = ir_q.pop_front();
        ctl.mem_ready = rdy_q.pop_front();
        @(negedge clk);
        got = sample();
        exp = exp_q.pop_front();
    endtask

    // scenarios
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (sample() !== '0) $display("FAIL reset_quiet got=%h exp=0", sample());
        else n_pass++;
    endtask

    task automatic test_and_rtype();
        logic [W-1:0] got, exp;
        int cyc = 0;
        do_reset();
        model_instr(32'h4A920000, 0, 0);
        model_instr(mk_ir(26, 0, 0, 0), 0, 0);
        while (exp_q.size() > 0) begin
            step(got, exp);
            n_checks++;
            if (got !== exp) $display("FAIL and_rtype cyc=%0d got=%h exp=%h", cyc, got, exp);
            else n_pass++;
            cyc++;
        end
    endtask

    task automatic test_fetch_wait();
        logic [W-1:0] got, exp;
        int cyc = 0;
        do_reset();
        model_instr(mk_ir(3, 1, 2, 3), 3, 0);
        model_instr(mk_ir(26, 0, 0, 0), 0, 0);
        while (exp_q.size() > 0) begin
            step(got, exp);
            n_checks++;
            if (got !== exp) $display("FAIL fetch_wait cyc=%0d got=%h exp=%h", cyc, got, exp);
            else n_pass++;
            cyc++;
        end
    endtask

    task automatic test_load_store();
        logic [W-1:0] got, exp;
        int cyc = 0;
        do_reset();
        model_instr({5'd0, 4'd1, 4'd0, 19'h10}, 0, int'($urandom_range(0, 3)));
        model_instr(mk_ir(0, 9, $urandom_range(1, 15), 0), 1, 2);
        model_instr(mk_ir(2, 3, $urandom_range(1, 15), 0), 0, 2);
        model_instr(mk_ir(2, 7, 0, 0), 0, 0);
        model_instr(mk_ir(1, 12, 0, 0), 0, 0);
        while (exp_q.size() > 0) begin
            step(got, exp);
            n_checks++;
            if (got !== exp) $display("FAIL load_store cyc=%0d got=%h exp=%h", cyc, got, exp);
            else n_pass++;
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got, exp;
        int cyc = 0;
        int op;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 14);
            if (op == 14) op = 26;
            model_instr(mk_ir(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
                        $urandom_range(0, 4), $urandom_range(0, 4));
        end
        while (exp_q.size() > 0) begin
            step(got, exp);
            n_checks++;
            if (got !== exp) $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, got, exp);
            else n_pass++;
            cyc++;
        end
    endtask

    task automatic test_halt_ops();
        logic [W-1:0] got, exp;
        int pick;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            pick = $urandom_range(0, 15);
            if (k == 0) model_instr(mk_ir(27, 1, 2, 3), 0, 0);
            else model_instr(mk_ir((pick < 12) ? 14 + pick : 16 + pick, 1, 2, 3), 1, 0);
            while (exp_q.size() > 0) begin
                step(got, exp);
                n_checks++;
                if (got !== exp) $display("FAIL halt_op k=%0d got=%h exp=%h", k, got, exp);
                else n_pass++;
            end
            n_checks++;
            if (dbg_state !== S_HALT) $display("FAIL halt_state k=%0d got=%0d exp=%0d", k, dbg_state, S_HALT);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] got, exp;
        int cyc = 0;
        do_reset();
        model_instr(mk_ir(26, 0, 0, 0), MEM_TIMEOUT - 1, 0);
        model_instr(mk_ir(3, 1, 2, 3), 300, 0);
        while (exp_q.size() > 0) begin
            step(got, exp);
            n_checks++;
            if (got !== exp) $display("FAIL fetch_timeout cyc=%0d got=%h exp=%h", cyc, got, exp);
            else n_pass++;
            cyc++;
        end
        n_checks++;
        if (dbg_state !== S_HALT) $display("FAIL fault_state got=%0d exp=%0d", dbg_state, S_HALT);
        else n_pass++;
        do_reset();
        model_instr(mk_ir(0, 4, 5, 0), 0, MEM_TIMEOUT);
        do_reset_keep_check();
        do_reset();
        model_instr(mk_ir(2, 6, 0, 0), 2, 400);
        while (exp_q.size() > 0) begin
            step(got, exp);
            n_checks++;
            if (got !== exp) $display("FAIL st_timeout cyc=%0d got=%h exp=%h", cyc, got, exp);
            else n_pass++;
            cyc++;
        end
        do_reset();
        @(negedge clk);
        n_checks++;
        if (sample() !== '0) $display("FAIL fault_cleared got=%h exp=0", sample());
        else n_pass++;
    endtask

    task automatic do_reset_keep_check();
        logic [W-1:0] got, exp;
        int cyc = 0;
        while (exp_q.size() > 0) begin
            step(got, exp);
            n_checks++;
            if (got !== exp) $display("FAIL ld_timeout cyc=%0d got=%h exp=%h", cyc, got, exp);
            else n_pass++;
            cyc++;
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] got, exp;
        obs_t t0;
        do_reset();
        model_instr(mk_ir(3, 2, 4, 6), 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(got, exp);
            n_checks++;
            if (got !== exp) $display("FAIL pre_reset cyc=%0d got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        exp_q.delete();
        rdy_q.delete();
        ir_q.delete();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sample() !== '0) $display("FAIL mid_reset_quiet got=%h exp=0", sample());
        else n_pass++;
        t0 = '0; t0.pc_out = 1; t0.mar_in = 1; t0.inc_pc = 1; t0.z_in = 1;
        @(negedge clk);
        n_checks++;
        if (sample() !== W'(t0)) $display("FAIL restart_t0 got=%h exp=%h", sample(), t0);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        reset = 1'b1;
        ctl.ir = '0;
        ctl.mem_ready = 1'b0;
        test_reset();
        test_and_rtype();
        test_fetch_wait();
        test_load_store();
        test_back_to_back();
        test_halt_ops();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
